// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus 2-bit bimodal direction table for a multi-slot fetch bundle.
// Lookup is combinational from registered state; training is applied at the clock edge.
`ifndef XLEN
`define XLEN 32
`endif

module branch_predictor #(
  parameter int NUM_ENTRIES = 16,
  parameter int FETCH_WIDTH = 3,
  parameter int IDX_BITS    = $clog2(NUM_ENTRIES),
  parameter int TAG_BITS    = `XLEN - IDX_BITS - 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               fetch_valid,
  input  logic [`XLEN-1:0]   fetch_pc,
  output logic               pred_taken,
  output logic [1:0]         pred_slot,
  output logic [`XLEN-1:0]   pred_target,
  output logic [`XLEN-1:0]   next_fetch_pc,
  input  logic               upd_valid,
  input  logic [`XLEN-1:0]   upd_pc,
  input  logic               upd_cond,
  input  logic               upd_uncond,
  input  logic               upd_taken,
  input  logic [`XLEN-1:0]   upd_target
);

  logic                valid_q  [NUM_ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [NUM_ENTRIES];
  logic [`XLEN-1:0]    target_q [NUM_ENTRIES];
  logic [1:0]          ctr_q    [NUM_ENTRIES];

  logic [FETCH_WIDTH-1:0] slot_taken;
  logic [`XLEN-1:0]       slot_target [FETCH_WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
      logic [`XLEN-1:0]    pc_s;
      logic [IDX_BITS-1:0] idx_s;
      logic [TAG_BITS-1:0] tag_s;
      logic                unused_pc_lo;

      assign pc_s           = fetch_pc + `XLEN'(4 * gi);
      assign idx_s          = pc_s[IDX_BITS+1:2];
      assign tag_s          = pc_s[`XLEN-1:IDX_BITS+2];
      assign unused_pc_lo   = ^pc_s[1:0];
      assign slot_taken[gi] = fetch_valid && valid_q[idx_s] &&
                              (tag_q[idx_s] == tag_s) && ctr_q[idx_s][1];
      assign slot_target[gi] = target_q[idx_s];
    end
  endgenerate

  // Descending scan so the lowest taken slot wins.
  always_comb begin
    pred_taken  = 1'b0;
    pred_slot   = 2'd0;
    pred_target = '0;
    for (int s = FETCH_WIDTH - 1; s >= 0; s--) begin
      if (slot_taken[s]) begin
        pred_taken  = 1'b1;
        pred_slot   = 2'(s);
        pred_target = slot_target[s];
      end
    end
  end

  assign next_fetch_pc = pred_taken ? pred_target : fetch_pc + `XLEN'(4 * FETCH_WIDTH);

  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_hit;
  logic                is_uncond;
  logic                is_cond;
  logic                unused_upd_lo;

  assign upd_idx       = upd_pc[IDX_BITS+1:2];
  assign upd_tag       = upd_pc[`XLEN-1:IDX_BITS+2];
  assign unused_upd_lo = ^upd_pc[1:0];
  assign upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign is_uncond     = upd_uncond;
  assign is_cond       = upd_cond && !upd_uncond;

  logic                wr_en;
  logic                valid_d;
  logic [TAG_BITS-1:0] tag_d;
  logic [`XLEN-1:0]    target_d;
  logic [1:0]          ctr_d;

  always_comb begin
    wr_en    = 1'b0;
    valid_d  = valid_q[upd_idx];
    tag_d    = tag_q[upd_idx];
    target_d = target_q[upd_idx];
    ctr_d    = ctr_q[upd_idx];
    if (upd_valid && (is_cond || is_uncond)) begin
      if (upd_hit) begin
        wr_en = 1'b1;
        if (is_uncond) begin
          ctr_d    = 2'b11;
          target_d = upd_target;
        end else if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'b11) ctr_d = ctr_q[upd_idx] + 2'd1;
          target_d = upd_target;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_d = ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocation replaces whatever alias currently owns the index.
        wr_en    = 1'b1;
        valid_d  = 1'b1;
        tag_d    = upd_tag;
        target_d = upd_target;
        ctr_d    = is_uncond ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        valid_q[e]  <= 1'b0;
        tag_q[e]    <= '0;
        target_q[e] <= '0;
        ctr_q[e]    <= 2'b01;
      end
    end else if (wr_en) begin
      valid_q[upd_idx]  <= valid_d;
      tag_q[upd_idx]    <= tag_d;
      target_q[upd_idx] <= target_d;
      ctr_q[upd_idx]    <= ctr_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized scoreboard bench for branch_predictor: a table-level reference model
// predicts each cycle's lookup result, a negedge monitor compares against the DUT.
`ifndef XLEN
`define XLEN 32
`endif

module tb_branch_predictor;

  localparam int N  = 16;
  localparam int IB = 4;
  localparam int FW = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = 32'h0;
  logic        pred_taken;
  logic [1:0]  pred_slot;
  logic [31:0] pred_target;
  logic [31:0] next_fetch_pc;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'h0;
  logic        upd_cond = 1'b0;
  logic        upd_uncond = 1'b0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = 32'h0;

  branch_predictor dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .pred_taken    (pred_taken),
    .pred_slot     (pred_slot),
    .pred_target   (pred_target),
    .next_fetch_pc (next_fetch_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_cond      (upd_cond),
    .upd_uncond    (upd_uncond),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        tk;
    logic [1:0]  slot;
    logic [31:0] tgt;
    logic [31:0] nfpc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference table: counter kept as a plain integer 0..3, "taken" means >= 2.
  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) % N;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (IB + 2);
  endfunction

  function automatic void model_clear();
    for (int e = 0; e < N; e++) begin
      m_valid[e] = 1'b0;
      m_tag[e]   = 0;
      m_tgt[e]   = 32'h0;
      m_ctr[e]   = 1;
    end
  endfunction

  function automatic exp_t model_predict(input logic fv, input logic [31:0] pc);
    exp_t        e;
    logic [31:0] p;
    int unsigned i;
    e.tk   = 1'b0;
    e.slot = 2'd0;
    e.tgt  = 32'h0;
    if (fv) begin
      for (int s = 0; s < FW; s++) begin
        p = pc + 32'(4 * s);
        i = idx_of(p);
        if (!e.tk && m_valid[i] && m_tag[i] == tag_of(p) && m_ctr[i] >= 2) begin
          e.tk   = 1'b1;
          e.slot = 2'(s);
          e.tgt  = m_tgt[i];
        end
      end
    end
    e.nfpc = e.tk ? e.tgt : pc + 32'(4 * FW);
    return e;
  endfunction

  function automatic void model_update(input logic [31:0] pc, input logic c, input logic u,
                                       input logic t, input logic [31:0] tg);
    int unsigned i;
    bit          hit;
    if (!c && !u) return;
    i   = idx_of(pc);
    hit = m_valid[i] && m_tag[i] == tag_of(pc);
    if (hit) begin
      if (u) begin
        m_ctr[i] = 3;
        m_tgt[i] = tg;
      end else if (t) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = tg;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (t) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tag_of(pc);
      m_tgt[i]   = tg;
      m_ctr[i]   = u ? 3 : 2;
    end
  endfunction

  // One cycle of stimulus: drive just after the edge, push the expected lookup result.
  task automatic step(input string nm, input logic fv, input logic [31:0] fpc,
                      input logic uv, input logic [31:0] upc, input logic uc, input logic uu,
                      input logic ut, input logic [31:0] utg, input logic rst_n);
    exp_t e;
    @(posedge clock);
    #1;
    reset_n     = rst_n;
    fetch_valid = fv;
    fetch_pc    = fpc;
    upd_valid   = uv;
    upd_pc      = upc;
    upd_cond    = uc;
    upd_uncond  = uu;
    upd_taken   = ut;
    upd_target  = utg;
    if (!rst_n) model_clear();
    e      = model_predict(fv, fpc);
    e.name = nm;
    exp_q.push_back(e);
    if (rst_n && uv) model_update(upc, uc, uu, ut, utg);
  endtask

  task automatic look(input string nm, input logic [31:0] fpc);
    step(nm, 1'b1, fpc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic train(input string nm, input logic [31:0] fpc, input logic [31:0] upc,
                       input logic c, input logic u, input logic t, input logic [31:0] tg);
    step(nm, 1'b1, fpc, 1'b1, upc, c, u, t, tg, 1'b1);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({pred_taken, pred_slot, pred_target, next_fetch_pc} !== {e.tk, e.slot, e.tgt, e.nfpc}) begin
        n_bad++;
        $display("FAIL %s: got tk=%0b slot=%0d tgt=%h nfpc=%h, want tk=%0b slot=%0d tgt=%h nfpc=%h",
                 e.name, pred_taken, pred_slot, pred_target, next_fetch_pc,
                 e.tk, e.slot, e.tgt, e.nfpc);
      end else begin
        $display("ok   %s: pc=%h tk=%0b slot=%0d tgt=%h nfpc=%h",
                 e.name, fetch_pc, pred_taken, pred_slot, pred_target, next_fetch_pc);
      end
    end
  end

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
    return 32'h100 + 32'(4 * $urandom_range(0, 63));
  endfunction

  initial begin
    model_clear();
    step("reset_idle", 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step("reset_fetch", 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h900, 1'b0);
    look("cold_lookup", 32'h100);
    train("train_104", 32'h100, 32'h104, 1'b1, 1'b0, 1'b1, 32'h200);
    look("hit_slot1", 32'h100);
    train("nt1_104", 32'h100, 32'h104, 1'b1, 1'b0, 1'b0, 32'h0);
    train("nt2_104", 32'h100, 32'h104, 1'b1, 1'b0, 1'b0, 32'h0);
    look("ctr00", 32'h100);
    train("t1_104", 32'h100, 32'h104, 1'b1, 1'b0, 1'b1, 32'h200);
    look("ctr01", 32'h100);
    train("t2_104", 32'h100, 32'h104, 1'b1, 1'b0, 1'b1, 32'h200);
    look("ctr10", 32'h100);
    for (int k = 0; k < 3; k++) train("sat_104", 32'h100, 32'h104, 1'b1, 1'b0, 1'b1, 32'h200);
    look("ctr11", 32'h100);
    train("nt_sat", 32'h100, 32'h104, 1'b1, 1'b0, 1'b0, 32'h0);
    look("ctr11_dec", 32'h100);
    train("unc_100", 32'h100, 32'h100, 1'b0, 1'b1, 1'b1, 32'h300);
    train("unc_108", 32'h100, 32'h108, 1'b0, 1'b1, 1'b1, 32'h400);
    look("lowest_slot", 32'h100);
    train("both_flags", 32'h100, 32'h10C, 1'b1, 1'b1, 1'b1, 32'h480);
    look("both_flags_chk", 32'h10C);
    look("alias_miss", 32'h144);
    train("alias_nt", 32'h104, 32'h144, 1'b1, 1'b0, 1'b0, 32'h500);
    look("alias_kept", 32'h104);
    train("alias_evict", 32'h104, 32'h144, 1'b1, 1'b0, 1'b1, 32'h500);
    look("alias_gone", 32'h104);
    look("alias_new", 32'h144);
    train("same_cycle", 32'h144, 32'h144, 1'b0, 1'b1, 1'b1, 32'h600);
    look("same_next", 32'h144);
    train("wrap_train", 32'hFFFF_FFF8, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h700);
    look("wrap_hit", 32'hFFFF_FFF8);
    look("wrap_nfpc", 32'hFFFF_FFFC);
    step("mid_reset", 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step("rst_release_upd", 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h800, 1'b1);
    look("after_release", 32'h100);
    look("after_reset_144", 32'h144);

    for (int n = 0; n < 1500; n++) begin
      logic [31:0] upc;
      logic        c, u;
      upc = rand_pc();
      c   = 1'($urandom_range(0, 1));
      u   = ($urandom_range(0, 3) == 0);
      step("rand", 1'($urandom_range(0, 7) != 0), rand_pc(),
           1'($urandom_range(0, 1)), upc, c, u, 1'($urandom_range(0, 2) != 0),
           $urandom() & 32'hFFFF_FFFC, ($urandom_range(0, 199) != 0));
    end

    repeat (2) @(negedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
